// File: rtl/jamma_pkg.sv
// Shared defaults and FSM encoding for the capture/display SRAM arbiter.
package jamma_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 8;
  localparam int WFIFO_DEPTH_DEF = 4;
  localparam int MAX_RD_RUN_DEF  = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    WR3  = 3'd5
  } arb_state_e;

endpackage

// File: rtl/sram_wr_fifo.sv
// Synchronous write buffer for capture bytes; exposes occupancy so the arbiter derives full/empty.
module sram_wr_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, empty, push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A push into a full buffer is still taken when the head leaves on the same edge.
  assign push_ok = push_i & (~full | pop_i);
  assign pop_ok  = pop_i & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one async SRAM between a buffered capture writer and a single-slot display reader.
module sram_arbiter
  import jamma_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WFIFO_DEPTH = WFIFO_DEPTH_DEF,
  parameter int MAX_RD_RUN  = MAX_RD_RUN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        overrun,
  output logic [ADDR_W-1:0] aMem,
  output logic [DATA_W-1:0] dMem_o,
  input  logic [DATA_W-1:0] dMem_i,
  output logic              dMem_oe,
  output logic              nCs,
  output logic              nOe,
  output logic              nWe
);

  localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;
  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

  arb_state_e        state_q, state_d;
  logic              slot_valid_q, slot_valid_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [ADDR_W-1:0] amem_q, amem_d;
  logic [DATA_W-1:0] dmem_q, dmem_d;
  logic [1:0]        overrun_q, overrun_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_empty, fifo_pop;
  logic              rd_pending, grant_rd, grant_wr;
  logic [ADDR_W-1:0] rd_pend_addr;

  sram_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_req),
    .pop_i   (fifo_pop),
    .wdata_i ({wr_addr, wr_data}),
    .rdata_o ({head_addr, head_data}),
    .count_o (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);
  assign wr_full    = (fifo_count == CNT_W'(WFIFO_DEPTH));
  assign fifo_pop   = (state_q == WR3);

  // A fresh rd_req in IDLE bypasses the slot so the access starts on the next edge.
  assign rd_pending   = slot_valid_q | rd_req;
  assign rd_pend_addr = slot_valid_q ? slot_addr_q : rd_addr;
  assign grant_rd     = (state_q == IDLE) & rd_pending &
                        (fifo_empty | (run_q < RUN_W'(MAX_RD_RUN)));
  assign grant_wr     = (state_q == IDLE) & ~grant_rd & ~fifo_empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    run_d        = run_q;
    amem_d       = amem_q;
    dmem_d       = dmem_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      IDLE:    if (grant_rd) state_d = RD1; else if (grant_wr) state_d = WR1;
      RD1:     state_d = RD2;
      RD2:     state_d = IDLE;
      WR1:     state_d = WR2;
      WR2:     state_d = WR3;
      WR3:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_rd) begin
      amem_d       = rd_pend_addr;
      slot_valid_d = 1'b0;
    end else if (grant_wr) begin
      amem_d = head_addr;
      dmem_d = head_data;
    end

    // Slot is free unless it holds a request whose access has not been granted yet.
    if (rd_req && !(grant_rd && !slot_valid_q)) begin
      if (!slot_valid_q || grant_rd) begin
        slot_valid_d = 1'b1;
        slot_addr_d  = rd_addr;
      end else begin
        overrun_d[1] = 1'b1;
      end
    end

    if (wr_req && wr_full && !fifo_pop) overrun_d[0] = 1'b1;

    if (fifo_empty)    run_d = '0;
    else if (grant_rd) run_d = run_q + RUN_W'(1);
    else if (grant_wr) run_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      slot_valid_q <= 1'b0;
      slot_addr_q  <= '0;
      run_q        <= '0;
      amem_q       <= '0;
      dmem_q       <= '0;
      overrun_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      run_q        <= run_d;
      amem_q       <= amem_d;
      dmem_q       <= dmem_d;
      overrun_q    <= overrun_d;
      rd_valid_q   <= (state_q == RD2);
      if (state_q == RD2) rd_data_q <= dMem_i;
    end
  end

  assign nCs      = (state_q == IDLE);
  assign nOe      = ~((state_q == RD1) | (state_q == RD2));
  assign nWe      = (state_q != WR2);
  assign dMem_oe  = (state_q == WR1) | (state_q == WR2) | (state_q == WR3);
  assign aMem     = amem_q;
  assign dMem_o   = dmem_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign overrun  = overrun_q;

endmodule
